instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_if.sv | 30 +++
 rtl/instr_mem_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus between a boot source and the loader.
// The master drives the byte stream and start request; the slave (loader) drives the rest.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_start;
    logic [10:0]       in_word_count;
    logic              in_byte_valid;
    logic [7:0]        in_byte;
    logic              out_byte_ready;
    logic              out_mem_we;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [31:0]       out_mem_wdata;
    logic              out_busy;
    logic              out_done;
    logic              out_error;
    logic [31:0]       out_checksum;

    modport master (
        output in_start, in_word_count, in_byte_valid, in_byte,
        input  out_byte_ready, out_mem_we, out_mem_addr, out_mem_wdata,
               out_busy, out_done, out_error, out_checksum
    );

    modport slave (
        input  in_start, in_word_count, in_byte_valid, in_byte,
        output out_byte_ready, out_mem_we, out_mem_addr, out_mem_wdata,
               out_busy, out_done, out_error, out_checksum
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a little-endian byte stream into instruction memory one 32-bit word at a time,
// holding the core busy and keeping a running XOR checksum of the written words.
//
// state | meaning
// IDLE  | waiting for a start with a legal word count
// RECV  | accepting bytes 0..3 of the current word
// WRITE | single-cycle memory write of the assembled word
// DONE  | single-cycle completion pulse, then back to IDLE
module instr_mem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    instr_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [10:0] DEPTH_C = 11'(DEPTH);

    state_t            state, state_nx;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic [ADDR_W-1:0] word_addr;
    logic [10:0]       word_cnt;
    logic [10:0]       cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       checksum_q;
    logic              error_q;

    logic cnt_ok;
    logic xfer;
    logic last_word;

    assign cnt_ok    = (bus.in_word_count != 11'd0) && (bus.in_word_count <= DEPTH_C);
    assign xfer      = (state == RECV) && bus.in_byte_valid;
    // Completion comes from the latched count so the address never has to wrap.
    assign last_word = ((word_cnt + 11'd1) == cnt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_start && cnt_ok) state_nx = RECV;
            RECV:    if (xfer && (byte_idx == 2'd3)) state_nx = WRITE;
            WRITE:   state_nx = last_word ? DONE : RECV;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.out_byte_ready = (state == RECV);
        bus.out_mem_we     = (state == WRITE);
        bus.out_busy       = (state != IDLE);
        bus.out_done       = (state == DONE);
        bus.out_mem_addr   = mem_addr_q;
        bus.out_mem_wdata  = mem_wdata_q;
        bus.out_error      = error_q;
        bus.out_checksum   = checksum_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx    <= 2'd0;
            asm_q       <= 24'd0;
            word_addr   <= '0;
            word_cnt    <= 11'd0;
            cnt_q       <= 11'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            checksum_q  <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_start) begin
                        if (cnt_ok) begin
                            byte_idx   <= 2'd0;
                            asm_q      <= 24'd0;
                            word_addr  <= '0;
                            word_cnt   <= 11'd0;
                            cnt_q      <= bus.in_word_count;
                            checksum_q <= 32'd0;
                            error_q    <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.in_byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_q[7:0]   <= bus.in_byte;
                            2'd1: asm_q[15:8]  <= bus.in_byte;
                            2'd2: asm_q[23:16] <= bus.in_byte;
                            default: begin
                                mem_addr_q  <= word_addr;
                                mem_wdata_q <= {bus.in_byte, asm_q};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    checksum_q <= checksum_q ^ mem_wdata_q;
                    word_cnt   <= word_cnt + 11'd1;
                    if (!last_word) word_addr <= word_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
